// File: rtl/onewire_master.sv
// onewire_master: clocked 1-wire bus master.
// Turns single-bit commands (reset/presence, write-0, write-1/read) into
// open-collector bus timing on owr_e. It returns the sampled bus bit, or the
// presence flag for a reset cycle, on a one-clock rsp_vld strobe.
// All bus timing is counted in ticks. A tick is CDR clk cycles long.
// Optional feature macro: ONEWIRE_MASTER_OVD_EN. When it is defined, ovd selects
// overdrive timing (CDR_O) for each command. Otherwise CDR_N is always used.
module onewire_master #(
    parameter int CDR_N = 15,
    parameter int CDR_O = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_vld,
    output logic cmd_rdy,
    input  logic cmd_rst,
    input  logic cmd_dat,
    input  logic ovd,
    output logic rsp_vld,
    output logic rsp_dat,
    output logic owr_e,
    input  logic owr_i
);

`ifdef ONEWIRE_MASTER_OVD_EN
    localparam int CDR_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
`else
    localparam int CDR_MAX = CDR_N;
    localparam int unused_cdr_o = CDR_O;
`endif
    localparam int DIV_W = (CDR_MAX > 2) ? $clog2(CDR_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_SMP  = 2'd2,
        ST_RCV  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [1:0]         sync_r;
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   cdr_m1_s;
    logic [7:0]         cnt_r;
    logic               cmd_rst_r;
    logic               cmd_dat_r;
    logic               sample_r;
    logic [7:0]         low_end_s;
    logic [7:0]         smp_s;
    logic [7:0]         end_s;
    logic               accept_s;
    logic               tick_s;
    logic               owr_e_s;
    logic               cmd_rdy_s;
    logic               rsp_vld_s;
    logic               rsp_dat_s;
    logic               owr_e_r;
    logic               cmd_rdy_r;
    logic               rsp_vld_r;
    logic               rsp_dat_r;

`ifdef ONEWIRE_MASTER_OVD_EN
    logic               ovd_r;

    // Latch the overdrive select of the accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovd_r <= 1'b0;
        end else if (accept_s) begin
            ovd_r <= ovd;
        end
    end

    // Select the tick length for the running command.
    always_comb begin
        cdr_m1_s = DIV_W'(CDR_N - 1);
        if (ovd_r) begin
            cdr_m1_s = DIV_W'(CDR_O - 1);
        end else begin
            cdr_m1_s = DIV_W'(CDR_N - 1);
        end
    end
`else
    logic               unused_ovd_s;
    assign unused_ovd_s = ovd;

    // Without overdrive support, the tick length is always the normal one.
    always_comb begin
        cdr_m1_s = DIV_W'(CDR_N - 1);
    end
`endif

    assign accept_s = cmd_vld & cmd_rdy_r;
    assign tick_s   = (state_r != ST_IDLE) && (div_r == cdr_m1_s);

    // Look up the low-end, sample and end tick positions for the latched command type.
    always_comb begin
        low_end_s = 8'd1;
        smp_s     = 8'd6;
        end_s     = 8'd16;
        if (cmd_rst_r) begin
            low_end_s = 8'd80;
            smp_s     = 8'd104;
            end_s     = 8'd144;
        end else if (!cmd_dat_r) begin
            low_end_s = 8'd12;
            smp_s     = 8'd6;
            end_s     = 8'd16;
        end else begin
            low_end_s = 8'd1;
            smp_s     = 8'd6;
            end_s     = 8'd16;
        end
    end

    // Bring the asynchronous bus input into the clk domain with two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], owr_i};
        end
    end

    // Latch the command type when the command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rst_r <= 1'b0;
            cmd_dat_r <= 1'b0;
        end else if (accept_s) begin
            cmd_rst_r <= cmd_rst;
            cmd_dat_r <= cmd_dat;
        end
    end

    // Run the clock divider and the tick counter. Both restart from zero when a command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
            cnt_r <= 8'd0;
        end else if (accept_s) begin
            div_r <= '0;
            cnt_r <= 8'd0;
        end else if (tick_s) begin
            div_r <= '0;
            cnt_r <= cnt_r + 8'd1;
        end else if (state_r != ST_IDLE) begin
            div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Capture the bus when the tick counter reaches the sample point.
    // This happens in whatever state the FSM is in. For write-0, the sample
    // point falls while the master is still pulling the bus low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r <= 1'b0;
        end else if (tick_s && (cnt_r == (smp_s - 8'd1))) begin
            sample_r <= sync_r[1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_LOW;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (tick_s && (cnt_r == (low_end_s - 8'd1))) begin
                    next_state_s = ST_SMP;
                end else begin
                    next_state_s = ST_LOW;
                end
            end
            ST_SMP: begin
                if (cnt_r >= smp_s) begin
                    next_state_s = ST_RCV;
                end else begin
                    next_state_s = ST_SMP;
                end
            end
            ST_RCV: begin
                if (tick_s && (cnt_r == (end_s - 8'd1))) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RCV;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode. The values computed here are registered on the next edge.
    always_comb begin
        owr_e_s   = (next_state_s == ST_LOW);
        cmd_rdy_s = (next_state_s == ST_IDLE);
        rsp_vld_s = 1'b0;
        rsp_dat_s = rsp_dat_r;
        if ((state_r == ST_RCV) && (next_state_s == ST_IDLE)) begin
            rsp_vld_s = 1'b1;
            rsp_dat_s = cmd_rst_r ? ~sample_r : sample_r;
        end else begin
            rsp_vld_s = 1'b0;
            rsp_dat_s = rsp_dat_r;
        end
    end

    // Output registers. Reset releases the bus at once and drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owr_e_r   <= 1'b0;
            cmd_rdy_r <= 1'b1;
            rsp_vld_r <= 1'b0;
            rsp_dat_r <= 1'b0;
        end else begin
            owr_e_r   <= owr_e_s;
            cmd_rdy_r <= cmd_rdy_s;
            rsp_vld_r <= rsp_vld_s;
            rsp_dat_r <= rsp_dat_s;
        end
    end

    assign owr_e   = owr_e_r;
    assign cmd_rdy = cmd_rdy_r;
    assign rsp_vld = rsp_vld_r;
    assign rsp_dat = rsp_dat_r;

endmodule
